// File: rtl/ibex_pkg.sv
// Shared types for the instruction-memory responder.
// A response record travels through the fixed-latency delay line as one packed word.
package ibex_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } imem_rsp_t;

  // Wide enough for MaxOutstanding up to 4
  localparam int unsigned OutCntW = 3;

endpackage

// File: rtl/ibex_imem_rsp_pipe.sv
// Fixed-latency delay line for instruction responses.
// All stages clear on reset, so aborted requests never reach the output.
module ibex_imem_rsp_pipe
  import ibex_pkg::*;
#(
  parameter int unsigned RspLatency = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  imem_rsp_t rsp_i,
  output imem_rsp_t rsp_o
);

  imem_rsp_t stage_q [RspLatency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RspLatency; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= rsp_i;
      for (int i = 1; i < RspLatency; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign rsp_o = stage_q[RspLatency-1];

endmodule

// File: rtl/ibex_imem_responder.sv
// Instruction-memory responder: grants fetches, answers each after a fixed latency,
// flags out-of-range or misaligned addresses, and accepts preload writes every cycle.
module ibex_imem_responder
  import ibex_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned RspLatency     = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        stall_i,
  input  logic                        load_we_i,
  input  logic [$clog2(MemWords)-1:0] load_addr_i,
  input  logic [31:0]                 load_wdata_i,
  output logic                        busy_o
);

  localparam int unsigned        IdxW     = $clog2(MemWords);
  localparam logic [32:0]        MemBytes = 33'(MemWords) << 2;
  localparam logic [OutCntW-1:0] MaxOut   = OutCntW'(MaxOutstanding);

  logic [31:0]        mem [MemWords];
  logic [OutCntW-1:0] outstanding_q, outstanding_d;
  logic [31:0]        offset;
  logic               addr_ok;
  logic [IdxW-1:0]    rd_idx;
  logic [31:0]        rd_word;
  imem_rsp_t          rsp_in, rsp_out;

  // Gated by rst_ni so nothing is granted while reset is held
  assign instr_gnt_o = rst_ni & instr_req_i & ~stall_i & (outstanding_q < MaxOut);

  // Addresses below BaseAddr wrap to a huge offset and fail the range check
  assign offset  = instr_addr_i - BaseAddr;
  assign addr_ok = (instr_addr_i[1:0] == 2'b00) && ({1'b0, offset} < MemBytes);
  assign rd_idx  = offset[IdxW+1:2];
  assign rd_word = mem[rd_idx];

  // Write lands at the clock edge, so a same-cycle read sees the old word
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = instr_gnt_o;
    if (instr_gnt_o) begin
      if (addr_ok) begin
        rsp_in.rdata = rd_word;
      end else begin
        rsp_in.err = 1'b1;
      end
    end
  end

  ibex_imem_rsp_pipe #(
    .RspLatency (RspLatency)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rsp_i  (rsp_in),
    .rsp_o  (rsp_out)
  );

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({instr_gnt_o, rsp_out.valid})
      2'b10:   outstanding_d = outstanding_q + OutCntW'(1);
      2'b01:   outstanding_d = outstanding_q - OutCntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  assign instr_rvalid_o = rsp_out.valid;
  assign instr_rdata_o  = rsp_out.valid ? rsp_out.rdata : 32'h0;
  assign instr_err_o    = rsp_out.valid & rsp_out.err;
  assign busy_o         = (outstanding_q != '0);

endmodule

// File: tb/tb_ibex_imem_responder.sv
// Scoreboard bench for ibex_imem_responder: a cycle model predicts grants and
// queues expected responses, which are compared when their due cycle arrives.
module tb_ibex_imem_responder;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int          LAT       = 3;
  localparam int          MAX_OUT   = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        stall_i;
  logic        load_we_i;
  logic [9:0]  load_addr_i;
  logic [31:0] load_wdata_i;
  logic        busy_o;

  ibex_imem_responder #(
    .MemWords       (MEM_WORDS),
    .BaseAddr       (32'h0000_0000),
    .RspLatency     (LAT),
    .MaxOutstanding (MAX_OUT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .stall_i        (stall_i),
    .load_we_i      (load_we_i),
    .load_addr_i    (load_addr_i),
    .load_wdata_i   (load_wdata_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [MEM_WORDS];
  int          model_out = 0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One cycle of inputs, held from just after a rising edge to the next one
  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic stall,
                               input logic we, input logic [9:0] waddr, input logic [31:0] wdata);
    instr_req_i  = req;
    instr_addr_i = addr;
    stall_i      = stall;
    load_we_i    = we;
    load_addr_i  = waddr;
    load_wdata_i = wdata;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
  endtask

  // Cycle model and checker, evaluated mid-cycle when inputs and outputs are stable
  always @(negedge clk_i) begin
    logic        exp_gnt;
    logic        exp_rv;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [31:0] off;
    exp_t        e;
    if (!rst_ni) begin
      exp_q.delete();
      model_out = 0;
      checkOutput("gnt_in_reset", 32'(instr_gnt_o), 32'h0);
      checkOutput("rvalid_in_reset", 32'(instr_rvalid_o), 32'h0);
      checkOutput("rdata_in_reset", instr_rdata_o, 32'h0);
      checkOutput("err_in_reset", 32'(instr_err_o), 32'h0);
      checkOutput("busy_in_reset", 32'(busy_o), 32'h0);
    end else begin
      exp_gnt  = instr_req_i && !stall_i && (model_out < MAX_OUT);
      exp_rv   = 1'b0;
      exp_err  = 1'b0;
      exp_data = 32'h0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e        = exp_q.pop_front();
        exp_rv   = 1'b1;
        exp_err  = e.err;
        exp_data = e.data;
      end
      checkOutput("gnt", 32'(instr_gnt_o), 32'(exp_gnt));
      checkOutput("rvalid", 32'(instr_rvalid_o), 32'(exp_rv));
      checkOutput("rdata", instr_rdata_o, exp_data);
      checkOutput("err", 32'(instr_err_o), 32'(exp_err));
      checkOutput("busy", 32'(busy_o), 32'(model_out != 0));
      if (exp_gnt) begin
        off   = instr_addr_i;
        e.due = cyc + LAT;
        if (off[1:0] != 2'b00 || off >= 32'(MEM_WORDS * 4)) begin
          e.err  = 1'b1;
          e.data = 32'h0;
        end else begin
          e.err  = 1'b0;
          e.data = model_mem[off / 4];
        end
        exp_q.push_back(e);
      end
      model_out = model_out + int'(exp_gnt) - int'(exp_rv);
    end
    if (load_we_i) model_mem[load_addr_i] = load_wdata_i;
    cyc++;
  end

  initial begin
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    // Request held during reset must not be granted
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    rst_ni = 1'b1;

    // Preload words 0..31; word 0 holds a NOP
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 10'(i),
                    (i == 0) ? 32'h0000_0013 : (32'hA500_0000 ^ (32'(i) * 32'h0101_0101)));
    end

    // Single fetch of word 0
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(LAT + 1);

    // Held request saturates the outstanding limit; address walks every cycle
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'(4 * (i + 1)), 1'b0, 1'b0, 10'd0, 32'h0);
    idle(LAT + 1);

    // Out-of-range, misaligned and wrapped addresses
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, 10'd0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0002, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(LAT);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 10'd0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(LAT + 1);

    // Same-cycle load to the word being read, then a re-read
    applyStimulus(1'b1, 32'h0000_0014, 1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h0000_0014, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(LAT + 1);

    // Stall a held request for five cycles, then release
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h0000_0008, 1'b1, 1'b0, 10'd0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0008, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(LAT + 1);

    // Reset with two requests in flight, then a fresh fetch (memory survives reset)
    applyStimulus(1'b1, 32'h0000_000C, 1'b0, 1'b0, 10'd0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, 10'd0, 32'h0);
    rst_ni = 1'b0;
    idle(LAT + 2);
    rst_ni = 1'b1;
    applyStimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(LAT + 1);

    // Random mix of fetches, stalls and preload traffic
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 31) * 4);
      applyStimulus(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 1) == 1, 10'($urandom_range(0, 31)), $urandom());
    end

    // Drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    checkOutput("drain_pending", 32'(exp_q.size()), 32'h0);
    checkOutput("drain_busy", 32'(busy_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ibex_imem_responder.md
IBEX_IMEM_RESPONDER -- requirements
Module: ibex_imem_responder

Interface
REQ-001 The block SHALL have parameter MemWords, default 1024, meaning the number of 32-bit words in the backing store (power of two).
REQ-002 The block SHALL have parameter BaseAddr, default 32'h0000_0000, meaning the byte address of word 0 (MemWords*4 aligned).
REQ-003 The block SHALL have parameter RspLatency, default 1, meaning the number of cycles from grant to rvalid (legal 1..4).
REQ-004 The block SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted-but-unanswered requests (legal 1..4).
REQ-005 The block SHALL have port clk_i, input, 1 bit, the clock.
REQ-006 The block SHALL have port rst_ni, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 The block SHALL have port instr_req_i, input, 1 bit, the fetch request from the core.
REQ-008 The block SHALL have port instr_addr_i, input, 32 bits, the fetch byte address.
REQ-009 The block SHALL have port instr_gnt_o, output, 1 bit, the request-accepted signal.
REQ-010 The block SHALL have port instr_rvalid_o, output, 1 bit, the response-valid signal.
REQ-011 The block SHALL have port instr_rdata_o, output, 32 bits, the response data.
REQ-012 The block SHALL have port instr_err_o, output, 1 bit, the response bus error, valid only with rvalid.
REQ-013 The block SHALL have port stall_i, input, 1 bit, the test hook that withholds grant.
REQ-014 The block SHALL have port load_we_i, input, 1 bit, the preload write enable.
REQ-015 The block SHALL have port load_addr_i, input, $clog2(MemWords) bits, the preload word index.
REQ-016 The block SHALL have port load_wdata_i, input, 32 bits, the preload write data.
REQ-017 The block SHALL have port busy_o, output, 1 bit, asserted while the outstanding count is nonzero.

Function
REQ-018 instr_gnt_o SHALL equal instr_req_i & ~stall_i & (outstanding_q < MaxOutstanding), combinationally in the same cycle.
REQ-019 outstanding_q SHALL increment on gnt, decrement on rvalid, and hold when both occur in the same cycle; a slot freed by rvalid is usable only from the next cycle.
REQ-020 Each granted request SHALL produce exactly one rvalid pulse exactly RspLatency cycles after its grant cycle, with responses returned in grant order.
REQ-021 The address SHALL be sampled in the grant cycle; later changes to instr_addr_i SHALL NOT affect that response.
REQ-022 A request whose address is outside [BaseAddr, BaseAddr+MemWords*4) or whose addr[1:0]!=0 SHALL respond with instr_err_o=1 and instr_rdata_o=0.
REQ-023 Otherwise the response SHALL carry mem[(addr-BaseAddr)>>2] read in the grant cycle, with instr_err_o=0.
REQ-024 A load write to the same word in the grant cycle SHALL NOT be visible in that response (read-before-write); it SHALL be visible to grants in later cycles.
REQ-025 Load writes SHALL be accepted every cycle regardless of request traffic.
REQ-026 When instr_rvalid_o=0, instr_rdata_o and instr_err_o SHALL be 0.
REQ-027 busy_o SHALL be (outstanding_q != 0).

Reset
REQ-028 Asserting rst_ni low SHALL clear outstanding_q and all in-flight response stages asynchronously; aborted requests SHALL never produce rvalid.
REQ-029 Under reset, rvalid, rdata, err and busy SHALL be 0, and gnt SHALL be 0.
REQ-030 Memory contents SHALL NOT be reset.

Structure
REQ-031 Response record type imem_rsp_t {valid, err, rdata[31:0]} SHALL be defined in ibex_pkg.
REQ-032 The fixed-latency delay line SHALL be a sub-module, ibex_imem_rsp_pipe, parameterised by RspLatency and carrying imem_rsp_t.
REQ-033 Address-range and alignment checks SHALL be local combinational logic; there SHALL be no other sub-modules.

Verification
REQ-034 With RspLatency=1, preload word0=32'h0000_0013 and a single request to 32'h0: gnt in cycle 0 -> rvalid=1, rdata=32'h0000_0013, err=0 in cycle 1.
REQ-035 With MaxOutstanding=2, RspLatency=3 and req held high: gnt in cycles 0 and 1, low in cycles 2-3, high again in cycle 4; rvalid in cycles 3 and 4, in order.
REQ-036 Requests to 32'h0000_1000 (MemWords=1024) and to 32'h2 -> rvalid with err=1, rdata=0.
REQ-037 A load write of 32'hDEAD_BEEF to word 5 in the same cycle as a granted read of 32'h14 -> response returns old data; a re-read the next cycle returns 32'hDEAD_BEEF.
REQ-038 rst_ni asserted low with 2 requests in flight -> no rvalid ever, busy_o=0; after release the first request is granted and answered normally.
REQ-039 With stall_i=1 for 5 cycles under a held request -> gnt=0 throughout, busy_o=0; on stall release gnt asserts in that cycle.
